regfile_2r1w_sb: RTL

//  Next-generation general-purpose register file for the NPC core: 2 combinational read ports,
//  1 write port, hardwired-zero register 0 and optional write-to-read bypass.

---
 rtl/regfile_2r1w_sb.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/regfile_2r1w_sb.sv
// -----------------------------------------------------------------------------
// regfile_2r1w_sb
//
// General-purpose register file for the NPC core, with a RAW-hazard scoreboard.
// It has two combinational read ports and one write port. Register 0 always
// reads zero. With BYPASS=1, write data in the current cycle is forwarded to the
// read ports.
//
// Decode marks an instruction's destination register as pending when it issues.
// Write-back clears the pending bit when it writes the register. Decode can then
// stall while a source register is still waiting for its producer.
//
// Parameters
//   ADDR_WIDTH : register index width, NREG = 2**ADDR_WIDTH entries
//   DATA_WIDTH : register data width
//   BYPASS     : 1 = forward same-cycle write data to the read and busy outputs
//   RESET_VAL  : reset value of registers 1..NREG-1
//
// Ports
//   clk, rst_n         : clock, asynchronous active-low reset
//   wen, waddr, wdata  : write-back port (the write lands on posedge)
//   raddr1 / rdata1    : read port 1 (combinational)
//   raddr2 / rdata2    : read port 2 (combinational)
//   iss_valid, iss_rd  : issue strobe, marks iss_rd as pending on posedge
//   busy1, busy2       : the register on the read port has a pending producer
//   busy_cnt           : registered count of pending registers
// -----------------------------------------------------------------------------
module regfile_2r1w_sb #(
  parameter int unsigned            ADDR_WIDTH = 5,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter bit                     BYPASS     = 1'b1,
  parameter logic [DATA_WIDTH-1:0]  RESET_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0] rdata1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata2,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  output logic                  busy1,
  output logic                  busy2,
  output logic [ADDR_WIDTH:0]   busy_cnt
);

  localparam int unsigned           NREG     = 2 ** ADDR_WIDTH;
  localparam logic [NREG-1:0]       BIT0     = {{(NREG-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_rf [NREG];
  logic [NREG-1:0]       r_pending;
  logic [ADDR_WIDTH:0]   r_busy_cnt;

  // ---------------------------------------------------------------------------
  // Write / issue decode. Index 0 is filtered out here, so register 0 can
  // never be written and can never become pending.
  // ---------------------------------------------------------------------------
  logic            w_wr_en;
  logic            w_iss_en;
  logic [NREG-1:0] w_wr_onehot;
  logic [NREG-1:0] w_iss_onehot;
  logic [NREG-1:0] w_pending_nxt;
  logic            w_cnt_inc;
  logic            w_cnt_dec;

  assign w_wr_en      = wen       && (waddr  != '0);
  assign w_iss_en     = iss_valid && (iss_rd != '0);
  assign w_wr_onehot  = w_wr_en  ? (BIT0 << waddr)  : '0;
  assign w_iss_onehot = w_iss_en ? (BIT0 << iss_rd) : '0;

  // The issue bit is applied after the write-back clear. When both target the
  // same index, the issued instruction is the newer producer, so it stays pending.
  assign w_pending_nxt = (r_pending & ~w_wr_onehot) | w_iss_onehot;

  // The count tracks only real transitions of the pending bits:
  //   - re-issuing an index that is already pending adds nothing;
  //   - writing an index that is not pending subtracts nothing;
  //   - a write that the same-cycle issue overrides subtracts nothing.
  // So busy_cnt always equals the number of pending bits and cannot wrap.
  assign w_cnt_inc = w_iss_en && !r_pending[iss_rd];
  assign w_cnt_dec = w_wr_en  &&  r_pending[waddr]
                              && !(w_iss_en && (iss_rd == waddr));

  // ---------------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------------
  // NOTE: the array has an explicit reset because every register must hold
  // RESET_VAL immediately after reset. Without that, the array could map to
  // plain RAM with no reset. Entry 0 is reset too but is never read, because
  // the read mux forces index 0 to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf[0] <= '0;
      for (int i = 1; i < int'(NREG); i++) begin
        r_rf[i] <= RESET_VAL;
      end
    end else if (w_wr_en) begin
      // NOTE: sequential state uses non-blocking assignments. Every always_ff
      // then reads pre-edge values, so the result does not depend on process order.
      r_rf[waddr] <= wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: pending bits and registered population count
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_cnt <= '0;
    end else begin
      unique case ({w_cnt_inc, w_cnt_dec})
        2'b10:   r_busy_cnt <= r_busy_cnt + CNT_ONE;
        2'b01:   r_busy_cnt <= r_busy_cnt - CNT_ONE;
        default: r_busy_cnt <= r_busy_cnt;
      endcase
    end
  end

  assign busy_cnt = r_busy_cnt;

  // ---------------------------------------------------------------------------
  // Read ports. Both ports use identical logic and are fully independent.
  // A bypass hit means the write port writes this register in this cycle.
  // The write data is forwarded to the read port. The busy output is
  // suppressed, because write-back is delivering the value now.
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] w_raddr [2];
  logic [DATA_WIDTH-1:0] w_rdata [2];
  logic                  w_busy  [2];

  assign w_raddr[0] = raddr1;
  assign w_raddr[1] = raddr2;

  for (genvar g = 0; g < 2; g++) begin : g_rport
    logic w_hit;

    assign w_hit = BYPASS && wen && (waddr == w_raddr[g]) && (w_raddr[g] != '0);

    // NOTE: every branch assigns w_rdata[g], starting with a default, so
    // no latch is inferred.
    always_comb begin
      w_rdata[g] = r_rf[w_raddr[g]];
      if (w_raddr[g] == '0) begin
        w_rdata[g] = '0;
      end else if (w_hit) begin
        w_rdata[g] = wdata;
      end
    end

    // Bit 0 of the pending vector is never set, so index 0 is never busy.
    assign w_busy[g] = r_pending[w_raddr[g]] && !w_hit;
  end

  assign rdata1 = w_rdata[0];
  assign rdata2 = w_rdata[1];
  assign busy1  = w_busy[0];
  assign busy2  = w_busy[1];

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_cnt_matches_pending : assert property (
    @(posedge clk) disable iff (!rst_n)
      r_busy_cnt == ADDR_WIDTH'(0) + ($countones(r_pending))
  );

  a_reg0_never_pending : assert property (
    @(posedge clk) disable iff (!rst_n) !r_pending[0]
  );

endmodule
